// File: rtl/input_wrapper_if.sv
// Handshake/data bundle between a serial word sender, the wrapper and the IMC.
// master: sender/IMC side (drives inValid, dataIn, imcAccept); slave: wrapper.
interface input_wrapper_if #(
  parameter int data_width = 16
);
  logic                  inValid;
  logic [data_width-1:0] dataIn;
  logic                  imcAccept;
  logic                  inReady;
  logic [data_width-1:0] dataOuta;
  logic [data_width-1:0] dataOutb;
  logic [data_width-1:0] dataOutc;
  logic [data_width-1:0] dataOutd;
  logic                  dataAvail;
  logic                  frameErr;
  logic [7:0]            frameCount;

  modport master (
    output inValid,
    output dataIn,
    output imcAccept,
    input  inReady,
    input  dataOuta,
    input  dataOutb,
    input  dataOutc,
    input  dataOutd,
    input  dataAvail,
    input  frameErr,
    input  frameCount
  );

  modport slave (
    input  inValid,
    input  dataIn,
    input  imcAccept,
    output inReady,
    output dataOuta,
    output dataOutb,
    output dataOutc,
    output dataOutd,
    output dataAvail,
    output frameErr,
    output frameCount
  );
endinterface

// File: rtl/input_wrapper.sv
// Assembles four serial words into a frame and presents it to the IMC.
// Ports: clk, rst (sync, active-high), bus (input_wrapper_if.slave).
module input_wrapper #(
  parameter int data_width = 16,
  parameter int timeout    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input_wrapper_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RECEIVE = 2'b01,
    PRESENT = 2'b10
  } state_t;

  localparam logic [7:0] GapLast = 8'(timeout - 1);

  state_t r_state;
  state_t w_next;

  logic [1:0]            r_idx;
  logic [7:0]            r_gap;
  logic [data_width-1:0] r_w0;
  logic [data_width-1:0] r_w1;
  logic [data_width-1:0] r_w2;
  logic [data_width-1:0] r_outa;
  logic [data_width-1:0] r_outb;
  logic [data_width-1:0] r_outc;
  logic [data_width-1:0] r_outd;
  logic [7:0]            r_cnt;
  logic                  r_err;

  logic w_ready;
  logic w_capture;
  logic w_done;
  logic w_tmo;

  assign w_ready   = (r_state == IDLE) || (r_state == RECEIVE);
  assign w_capture = bus.inValid && w_ready && !rst;

  assign bus.inReady    = w_ready && !rst;
  assign bus.dataAvail  = (r_state == PRESENT) && !rst;
  assign bus.dataOuta   = r_outa;
  assign bus.dataOutb   = r_outb;
  assign bus.dataOutc   = r_outc;
  assign bus.dataOutd   = r_outd;
  assign bus.frameErr   = r_err;
  assign bus.frameCount = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // A capture on the last allowed gap cycle wins over the timeout.
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_tmo  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_capture) w_next = RECEIVE;
      end
      RECEIVE: begin
        if (w_capture) begin
          if (r_idx == 2'd3) begin
            w_done = 1'b1;
            w_next = PRESENT;
          end
        end else if (r_gap == GapLast) begin
          w_tmo  = 1'b1;
          w_next = IDLE;
        end
      end
      PRESENT: begin
        if (bus.imcAccept) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_gap  <= '0;
      r_w0   <= '0;
      r_w1   <= '0;
      r_w2   <= '0;
      r_outa <= '0;
      r_outb <= '0;
      r_outc <= '0;
      r_outd <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_tmo;
      if (w_capture) begin
        r_gap <= '0;
        if (r_state == IDLE) begin
          r_w0  <= bus.dataIn;
          r_idx <= 2'd1;
        end else begin
          r_idx <= r_idx + 2'd1;
          unique case (r_idx)
            2'd0: r_w0 <= bus.dataIn;
            2'd1: r_w1 <= bus.dataIn;
            2'd2: r_w2 <= bus.dataIn;
            default: begin
              // Last word goes straight out with the shadowed three.
              r_outa <= r_w0;
              r_outb <= r_w1;
              r_outc <= r_w2;
              r_outd <= bus.dataIn;
              r_cnt  <= r_cnt + 8'd1;
            end
          endcase
        end
      end else if (w_tmo) begin
        r_gap <= '0;
        r_idx <= '0;
      end else if (r_state == RECEIVE) begin
        r_gap <= r_gap + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_input_wrapper.sv
// Scoreboard bench for input_wrapper.
// Frames are pushed on send and popped when dataAvail rises.
module tb_input_wrapper;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  input_wrapper_if #(.data_width(16)) bus ();

  input_wrapper #(
    .data_width(16),
    .timeout   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_chk  = 0;
  int          n_err  = 0;
  int          n_ferr = 0;
  logic [71:0] sb[$];
  logic [71:0] mon_e;
  logic [7:0]  exp_cnt = 8'd0;
  logic        prev_av = 1'b0;

  task automatic check(input string tag,
                       input logic [71:0] got,
                       input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {bus.dataOuta, bus.dataOutb,
            bus.dataOutc, bus.dataOutd};
  endfunction

  always @(negedge clk) begin
    if (bus.frameErr) n_ferr++;
    if (bus.dataAvail && !prev_av) begin
      if (sb.size() == 0) begin
        check("sb_empty", 72'd0, 72'd1);
      end else begin
        mon_e = sb.pop_front();
        check("frame", {bus.frameCount, outs()}, mon_e);
      end
    end
    prev_av = bus.dataAvail;
  end

  task automatic send(input logic [15:0] w);
    bit ok;
    int n;
    n = 0;
    bus.inValid = 1'b1;
    bus.dataIn  = w;
    do begin
      ok = bus.inReady;
      @(negedge clk);
      n++;
    end while (!ok && n < 50);
    bus.inValid = 1'b0;
    if (!ok) check("send_timeout", 72'd0, 72'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic [15:0] w0, w1, w2, w3,
                       input int gap);
    exp_cnt = exp_cnt + 8'd1;
    sb.push_back({exp_cnt, w0, w1, w2, w3});
    send(w0); idle(gap);
    send(w1); idle(gap);
    send(w2); idle(gap);
    send(w3);
  endtask

  task automatic accept();
    bus.imcAccept = 1'b1;
    @(negedge clk);
    bus.imcAccept = 1'b0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.inValid = 1'b0;
    exp_cnt     = 8'd0;
    idle(2);
    check("rst_rdy", 72'(bus.inReady), 72'd0);
    check("rst_av", 72'(bus.dataAvail), 72'd0);
    check("rst_out", 72'(outs()), 72'd0);
    check("rst_cnt", 72'(bus.frameCount), 72'd0);
    check("rst_err", 72'(bus.frameErr), 72'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 72'(bus.inReady), 72'd1);
  endtask

  initial begin
    bus.inValid   = 1'b0;
    bus.dataIn    = '0;
    bus.imcAccept = 1'b0;
    @(negedge clk);
    do_reset();

    // basic frame
    frame(16'h000A, 16'h000B, 16'h000C, 16'h000D, 0);
    check("av_first", 72'(bus.dataAvail), 72'd1);
    check("rdy_present", 72'(bus.inReady), 72'd0);
    accept();
    check("av_after_acc", 72'(bus.dataAvail), 72'd0);
    check("hold_out", 72'(outs()), 72'h000A000B000C000D);
    check("cnt1", 72'(bus.frameCount), 72'd1);

    // gaps of 3, then 7 (capture on the timeout cycle)
    frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 3);
    accept();
    frame(16'h5555, 16'h6666, 16'h7777, 16'h8888, 7);
    accept();
    check("no_ferr_gaps", 72'(n_ferr), 72'd0);

    // timeout drops a partial frame
    do_reset();
    send(16'h0011);
    send(16'h0022);
    idle(7);
    check("ferr_early", 72'(bus.frameErr), 72'd0);
    idle(1);
    check("ferr_pulse", 72'(bus.frameErr), 72'd1);
    check("ferr_idle", 72'(bus.inReady), 72'd1);
    check("ferr_out", 72'(outs()), 72'd0);
    check("ferr_cnt", 72'(bus.frameCount), 72'd0);
    idle(1);
    check("ferr_end", 72'(bus.frameErr), 72'd0);
    check("ferr_total", 72'(n_ferr), 72'd1);
    frame(16'h0001, 16'h0002, 16'h0003, 16'h0004, 0);
    accept();

    // inValid ignored while presenting
    frame(16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4, 0);
    bus.inValid = 1'b1;
    bus.dataIn  = 16'h00FF;
    repeat (5) begin
      check("pres_rdy", 72'(bus.inReady), 72'd0);
      check("pres_out", 72'(outs()), 72'h00A100A200A300A4);
      @(negedge clk);
    end
    accept();
    frame(16'h00FF, 16'h00B1, 16'h00B2, 16'h00B3, 0);
    accept();

    // reset mid-frame
    send(16'h00C1);
    send(16'h00C2);
    send(16'h00C3);
    rst = 1'b1;
    exp_cnt = 8'd0;
    @(negedge clk);
    check("mid_rst_out", 72'(outs()), 72'd0);
    check("mid_rst_cnt", 72'(bus.frameCount), 72'd0);
    check("mid_rst_rdy", 72'(bus.inReady), 72'd0);
    rst = 1'b0;
    @(negedge clk);
    frame(16'h00D1, 16'h00D2, 16'h00D3, 16'h00D4, 0);
    accept();
    check("mid_rst_ferr", 72'(n_ferr), 72'd1);

    // wrap frameCount; odd frames keep imcAccept high throughout
    for (int i = 0; i < 255; i++) begin
      bus.imcAccept = (i % 2 == 1);
      frame(16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom), i % 3);
      accept();
    end
    check("wrap_cnt", 72'(bus.frameCount), 72'd0);
    check("sb_drained", 72'(sb.size()), 72'd0);
    check("ferr_final", 72'(n_ferr), 72'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/input_wrapper.md
INPUT_WRAPPER -- requirements
Module: input_wrapper

Interface
REQ-001 SHALL have parameter data_width, default 16, width of every data word.
REQ-002 SHALL have parameter timeout, default 8, max idle cycles allowed between words of one frame (range 2..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port inValid  input  1  dataIn carries a valid word this cycle (driven by the sender's outReady).
REQ-006 SHALL have port dataIn  input  data_width  serial word from the bus.
REQ-007 SHALL have port imcAccept  input  1  IMC has consumed the presented frame.
REQ-008 SHALL have port inReady  output  1  wrapper can capture a word this cycle.
REQ-009 SHALL have ports dataOuta, dataOutb, dataOutc, dataOutd  output  data_width each  words 0..3 of the last completed frame.
REQ-010 SHALL have port dataAvail  output  1  complete frame presented to IMC.
REQ-011 SHALL have port frameErr  output  1  one-cycle pulse: partial frame dropped on timeout.
REQ-012 SHALL have port frameCount  output  8  number of completed frames, modulo 256.

Function
REQ-013 SHALL implement an FSM with states IDLE, RECEIVE, PRESENT; unused encodings SHALL go to IDLE.
REQ-014 SHALL capture a word only when inValid && inReady in the same cycle ("capture").
REQ-015 IDLE: inReady=1, dataAvail=0; on capture, store dataIn as word 0, set word index to 1, go RECEIVE.
REQ-016 RECEIVE: inReady=1; each capture stores dataIn at word[index] and increments the 2-bit index.
REQ-017 Capture of word 3 in RECEIVE SHALL: go PRESENT next cycle, wrap index to 0, copy all four shadow words to dataOuta..d in the same edge, increment frameCount.
REQ-018 Words SHALL land in order: first capture -> dataOuta, second -> dataOutb, third -> dataOutc, fourth -> dataOutd.
REQ-019 dataOuta..d SHALL change only on the REQ-017 edge or reset; partial frames SHALL never appear on dataOut*.
REQ-020 Gaps allowed: a gap counter SHALL clear on every capture and increment on each RECEIVE cycle without capture.
REQ-021 When timeout consecutive non-capture cycles elapse in RECEIVE, SHALL pulse frameErr for exactly one cycle, clear index and gap counter, go IDLE; frameCount unchanged.
REQ-022 A capture on the cycle the gap counter would reach timeout SHALL take priority; no frameErr.
REQ-023 PRESENT: dataAvail=1, inReady=0; inValid ignored (sender holds data until inReady).
REQ-024 PRESENT with imcAccept=1: go IDLE next cycle; dataAvail low from that cycle; dataOut* hold their values.
REQ-025 imcAccept outside PRESENT SHALL be ignored.
REQ-026 Minimum frame latency: last capture at edge N -> dataAvail=1 in cycle after N; back-to-back frames SHALL have at least one non-ready cycle (PRESENT).
REQ-027 frameCount SHALL wrap 255 -> 0 with no flag.

Reset
REQ-028 With rst=1 at a clock edge: state IDLE, index 0, gap counter 0, dataOuta..d 0, frameCount 0, frameErr 0.
REQ-029 inReady and dataAvail SHALL be 0 while rst=1; inReady=1 the first cycle after rst deasserts.
REQ-030 Reset mid-frame SHALL discard captured words with no frameErr pulse.

Verification
REQ-031 Reset, then inValid=1 for 4 cycles with dataIn 0x0A,0x0B,0x0C,0x0D -> dataOuta..d=0x0A..0x0D, dataAvail=1 next cycle, frameCount=1.
REQ-032 Frame with 3-cycle gaps between words (timeout=8) -> frame completes normally, frameErr never 1.
REQ-033 Two words then 8 idle cycles -> frameErr one-cycle pulse, state IDLE, dataOut* still 0, frameCount 0.
REQ-034 In PRESENT, hold inValid=1 with 0xFF for 5 cycles, imcAccept=0 -> inReady=0, dataOut* unchanged; assert imcAccept -> IDLE, next word captured as word 0.
REQ-035 rst=1 after third word of frame -> all outputs 0; following 4-word frame presents only new words.
REQ-036 256 complete frames -> frameCount returns to 0.
